// File: rtl/mem_stage.sv
// Load/store stage: issues data-bus accesses for execute results and forms aligned writeback data.
// Latency: NONE/misaligned 1 cycle, store 2 cycles, load 3 cycles minimum (accept -> valid_o).
// Backpressure: ready_o low (stall_o high) while a bus access is outstanding; the bus stalls via dmem_gnt_i/dmem_rvalid_i.
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   valid_i/ready_o/flush_i          execute handshake and branch-redirect kill
//   alu_res_i, store_data_i          effective address / result, rs2 store data
//   mem_op_i, rd_addr_i, rd_we_i     access type and destination register
//   dmem_*                           request/grant/rvalid data-bus port
//   valid_o, wb_data_o, rd_addr_o,
//   rd_we_o, exc_o, exc_cause_o      writeback result (one-cycle pulse) and misalignment exception
//   stall_o                          pipeline stall while an access is in flight
module mem_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] alu_res_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [3:0]            mem_op_i,
  input  logic [4:0]            rd_addr_i,
  input  logic                  rd_we_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic [4:0]            rd_addr_o,
  output logic                  rd_we_o,
  output logic                  exc_o,
  output logic [3:0]            exc_cause_o,
  output logic                  stall_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1001;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1011;

  localparam logic [1:0] SZ_B    = 2'd0;
  localparam logic [1:0] SZ_H    = 2'd1;
  localparam logic [1:0] SZ_W    = 2'd2;
  localparam logic [1:0] SZ_NONE = 2'd3;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;

  // Access size; unknown encodings fall into SZ_NONE and are treated as plain results.
  function automatic logic [1:0] op_size(input logic [3:0] op);
    logic [1:0] sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_B;
      OP_LH, OP_LHU, OP_SH: sz = SZ_H;
      OP_LW, OP_SW:         sz = SZ_W;
      default:              sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // State and latched instruction fields
  logic [1:0]            state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [4:0]            rd_q, rd_d;
  logic                  rd_we_q, rd_we_d;
  // Set when a flush hits a load whose bus access must still complete
  logic                  drop_q, drop_d;

  // Writeback outputs
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  wb_we_q, wb_we_d;
  logic                  exc_q, exc_d;
  logic [3:0]            cause_q, cause_d;

  // Decode of the incoming instruction
  logic                  accept;
  logic [1:0]            in_size;
  logic                  in_store;
  logic                  in_mem;
  logic                  in_misalign;
  logic [3:0]            in_be;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic                  in_rd_we;

  assign accept    = valid_i && (state_q == S_IDLE) && !flush_i;
  assign in_size   = op_size(mem_op_i);
  assign in_store  = op_is_store(mem_op_i);
  assign in_mem    = (in_size != SZ_NONE);
  assign in_rd_we  = rd_we_i && (rd_addr_i != 5'd0);
  assign in_misalign = ((in_size == SZ_H) && alu_res_i[0]) ||
                       ((in_size == SZ_W) && (alu_res_i[1:0] != 2'b00));

  always_comb begin
    in_be    = 4'b0000;
    in_wdata = store_data_i;
    case (in_size)
      SZ_B: begin
        in_be    = 4'b0001 << alu_res_i[1:0];
        in_wdata = {4{store_data_i[7:0]}};
      end
      SZ_H: begin
        in_be    = 4'b0011 << {alu_res_i[1], 1'b0};
        in_wdata = {2{store_data_i[15:0]}};
      end
      SZ_W: begin
        in_be    = 4'b1111;
        in_wdata = store_data_i;
      end
      default: begin
        in_be    = 4'b0000;
        in_wdata = store_data_i;
      end
    endcase
  end

  // Lane extraction for load data, using the address latched at accept
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (op_q)
      OP_LB:   ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      OP_LH:   ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    drop_d    = drop_q;
    valid_d   = 1'b0;
    wb_data_d = wb_data_q;
    wb_we_d   = 1'b0;
    exc_d     = 1'b0;
    cause_d   = cause_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = mem_op_i;
          addr_d  = alu_res_i[ADDR_WIDTH-1:0];
          be_d    = in_be;
          wdata_d = in_wdata;
          rd_d    = rd_addr_i;
          rd_we_d = in_rd_we;
          drop_d  = 1'b0;
          if (!in_mem) begin
            valid_d   = 1'b1;
            wb_data_d = alu_res_i;
            wb_we_d   = in_rd_we;
          end else if (in_misalign) begin
            // Faulting access never reaches the bus; the bad address is reported as data
            valid_d   = 1'b1;
            wb_data_d = alu_res_i;
            exc_d     = 1'b1;
            cause_d   = in_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
          end else begin
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (dmem_gnt_i) begin
          // A grant commits the access on the bus even if a flush arrives with it
          if (op_is_store(op_q)) begin
            state_d = S_IDLE;
            valid_d = !flush_i;
          end else begin
            state_d = S_WAIT;
            drop_d  = flush_i;
          end
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (flush_i) begin
          drop_d = 1'b1;
        end
        if (dmem_rvalid_i) begin
          state_d = S_IDLE;
          if (!(drop_q || flush_i)) begin
            valid_d   = 1'b1;
            wb_data_d = ld_data;
            wb_we_d   = rd_we_q;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      op_q      <= 4'd0;
      addr_q    <= '0;
      be_q      <= 4'd0;
      wdata_q   <= '0;
      rd_q      <= 5'd0;
      rd_we_q   <= 1'b0;
      drop_q    <= 1'b0;
      valid_q   <= 1'b0;
      wb_data_q <= '0;
      wb_we_q   <= 1'b0;
      exc_q     <= 1'b0;
      cause_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      drop_q    <= drop_d;
      valid_q   <= valid_d;
      wb_data_q <= wb_data_d;
      wb_we_q   <= wb_we_d;
      exc_q     <= exc_d;
      cause_q   <= cause_d;
    end
  end

  assign ready_o      = (state_q == S_IDLE);
  assign stall_o      = (state_q != S_IDLE);
  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_we_o    = (state_q == S_REQ) && op_is_store(op_q);
  assign dmem_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

  assign valid_o      = valid_q;
  assign wb_data_o    = wb_data_q;
  assign rd_addr_o    = rd_q;
  assign rd_we_o      = wb_we_q;
  assign exc_o        = exc_q;
  assign exc_cause_o  = cause_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus randomized transactions against a byte-lane reference model.
// Latency: inputs driven and outputs sampled on the falling edge, one cycle per rising edge.
// Backpressure: the bench plays the bus, with random grant and rvalid delays.
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [31:0] alu_res_i;
  logic [31:0] store_data_i;
  logic [3:0]  mem_op_i;
  logic [4:0]  rd_addr_i;
  logic        rd_we_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;
  logic        exc_o;
  logic [3:0]  exc_cause_o;
  logic        stall_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mem_stage dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .flush_i       (flush_i),
    .alu_res_i     (alu_res_i),
    .store_data_i  (store_data_i),
    .mem_op_i      (mem_op_i),
    .rd_addr_i     (rd_addr_i),
    .rd_we_i       (rd_we_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .valid_o       (valid_o),
    .wb_data_o     (wb_data_o),
    .rd_addr_o     (rd_addr_o),
    .rd_we_o       (rd_we_o),
    .exc_o         (exc_o),
    .exc_cause_o   (exc_cause_o),
    .stall_o       (stall_o)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_bytes(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0100, 4'b1001: return 1;
      4'b0010, 4'b0101, 4'b1010: return 2;
      4'b0011, 4'b1011:          return 4;
      default:                   return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [3:0] op);
    return op_bytes(op) != 0 && op[3];
  endfunction

  function automatic bit op_signed(input logic [3:0] op);
    return (op == 4'b0001) || (op == 4'b0010);
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] op, input logic [31:0] a);
    int n = op_bytes(op);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  // Each byte lane carries store byte (lane mod access size)
  function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] sd);
    int n = op_bytes(op);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      r = r | (((sd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    end
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w);
    int n = op_bytes(op);
    longint unsigned mask = (64'd1 << (8 * n)) - 1;
    longint unsigned v = (64'(w) >> (8 * (a % 4))) & mask;
    if (op_signed(op) && (((v >> (8 * n - 1)) & 1) != 0)) v = v | ~mask;
    return v[31:0];
  endfunction

  // fmode: 0 none, 1 flush in REQ before grant, 2 flush with grant (store) / in WAIT (load), 3 flush with valid_i
  task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input logic we, input int gdly, input int rdly,
                         input int fmode, input logic [31:0] rdata);
    int  n;
    bit  st, mis;
    n   = op_bytes(op);
    st  = op_store(op);
    mis = (n != 0) && ((a % n) != 0);

    valid_i = 1'b1; mem_op_i = op; alu_res_i = a; store_data_i = sd;
    rd_addr_i = rd; rd_we_i = we; flush_i = (fmode == 3);
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0;

    if (fmode == 3) begin
      check_val("flush_idle_valid", valid_o, 0);
      check_val("flush_idle_ready", ready_o, 1);
      check_val("flush_idle_req", dmem_req_o, 0);
      return;
    end
    if (n == 0 || mis) begin
      check_val("direct_valid", valid_o, 1);
      check_val("direct_req", dmem_req_o, 0);
      check_val("direct_exc", exc_o, mis);
      check_val("direct_rd", rd_addr_o, rd);
      if (mis) begin
        check_val("exc_cause", exc_cause_o, st ? 6 : 4);
        check_val("exc_rd_we", rd_we_o, 0);
      end else begin
        check_val("none_wb", wb_data_o, a);
        check_val("none_rd_we", rd_we_o, we && rd != 0);
      end
      return;
    end

    for (int i = 0; i <= gdly; i++) begin
      if (i > 0) @(negedge clk_i);
      check_val("req", dmem_req_o, 1);
      check_val("req_we", dmem_we_o, st);
      check_val("req_addr", dmem_addr_o, a & 32'hFFFF_FFFC);
      check_val("req_be", dmem_be_o, model_be(op, a));
      if (st) check_val("req_wdata", dmem_wdata_o, model_wdata(op, sd));
      check_val("req_stall", stall_o, 1);
      check_val("req_no_valid", valid_o, 0);
      if (fmode == 1 && i == gdly) begin
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check_val("flushreq_req", dmem_req_o, 0);
        check_val("flushreq_valid", valid_o, 0);
        check_val("flushreq_ready", ready_o, 1);
        return;
      end
    end

    dmem_gnt_i = 1'b1;
    flush_i = (fmode == 2) && st;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0; flush_i = 1'b0;
    if (st) begin
      check_val("st_valid", valid_o, fmode != 2);
      check_val("st_rd_we", rd_we_o, 0);
      check_val("st_exc", exc_o, 0);
      check_val("st_ready", ready_o, 1);
      return;
    end

    check_val("wait_req", dmem_req_o, 0);
    check_val("wait_stall", stall_o, 1);
    for (int i = 0; i < rdly; i++) begin
      flush_i = (fmode == 2) && (i == 0);
      @(negedge clk_i);
      flush_i = 1'b0;
      check_val("wait_no_valid", valid_o, 0);
    end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
    flush_i = (fmode == 2) && (rdly == 0);
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0; flush_i = 1'b0;
    check_val("ld_valid", valid_o, fmode != 2);
    check_val("ld_ready", ready_o, 1);
    if (fmode != 2) begin
      check_val("ld_wb", wb_data_o, model_load(op, a, rdata));
      check_val("ld_rd_we", rd_we_o, we && rd != 0);
      check_val("ld_exc", exc_o, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, valid_o, 0);
    check_val({tag, "_req"}, dmem_req_o, 0);
    check_val({tag, "_we"}, dmem_we_o, 0);
    check_val({tag, "_addr"}, dmem_addr_o, 0);
    check_val({tag, "_be"}, dmem_be_o, 0);
    check_val({tag, "_wdata"}, dmem_wdata_o, 0);
    check_val({tag, "_wb"}, wb_data_o, 0);
    check_val({tag, "_rd"}, rd_addr_o, 0);
    check_val({tag, "_rdwe"}, rd_we_o, 0);
    check_val({tag, "_exc"}, exc_o, 0);
    check_val({tag, "_cause"}, exc_cause_o, 0);
    check_val({tag, "_stall"}, stall_o, 0);
    check_val({tag, "_ready"}, ready_o, 1);
  endtask

  logic [3:0] ops [10];

  initial begin
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1001, 4'b1010, 4'b1011, 4'b0000};
    rst_ni = 1'b0; valid_i = 1'b0; flush_i = 1'b0; alu_res_i = '0; store_data_i = '0;
    mem_op_i = '0; rd_addr_i = '0; rd_we_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // directed cases
    run_txn(4'b0000, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 0, 0, 0, 32'h0);
    check_val("d_none_wb", wb_data_o, 32'h1234_5678);
    run_txn(4'b0001, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 0, 0, 0, 32'h80FF_FF7F);
    check_val("d_lb_wb", wb_data_o, 32'hFFFF_FF80);
    run_txn(4'b0100, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 1, 2, 0, 32'h80FF_FF7F);
    check_val("d_lbu_wb", wb_data_o, 32'h0000_0080);
    run_txn(4'b1010, 32'h0000_0202, 32'hAAAA_BEEF, 5'd0, 1'b0, 3, 0, 0, 32'h0);
    run_txn(4'b0011, 32'h0000_0301, 32'h0, 5'd3, 1'b1, 0, 0, 0, 32'h0);
    check_val("d_lw_mis_cause", exc_cause_o, 4);
    run_txn(4'b1011, 32'h0000_0302, 32'h0, 5'd3, 1'b1, 0, 0, 0, 32'h0);
    check_val("d_sw_mis_cause", exc_cause_o, 6);
    run_txn(4'b0011, 32'h0000_0400, 32'h0, 5'd9, 1'b1, 2, 0, 1, 32'h0);
    run_txn(4'b0011, 32'h0000_0404, 32'h0, 5'd9, 1'b1, 0, 2, 2, 32'h1111_2222);
    run_txn(4'b0000, 32'h0000_0055, 32'h0, 5'd1, 1'b1, 0, 0, 3, 32'h0);

    // reset while waiting for load data
    valid_i = 1'b1; mem_op_i = 4'b0011; alu_res_i = 32'h0000_0500; rd_addr_i = 5'd4; rd_we_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0; dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    check_val("rst_pre_stall", stall_o, 1);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk_i);
    rst_ni = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    check_val("rst_late_rvalid", valid_o, 0);
    check_val("rst_late_ready", ready_o, 1);
    run_txn(4'b0011, 32'h0000_0508, 32'h0, 5'd4, 1'b1, 0, 0, 0, 32'hCAFE_F00D);
    check_val("rst_after_lw", wb_data_o, 32'hCAFE_F00D);

    // randomized transactions
    for (int t = 0; t < 400; t++) begin
      logic [3:0]  op;
      logic [31:0] a;
      int          fm;
      int          gd;
      op = ops[$urandom_range(0, 9)];
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      fm = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
      gd = $urandom_range(0, 3);
      if (fm == 1 && gd == 0) gd = 1;
      run_txn(op, a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              gd, $urandom_range(0, 3), fm, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
